// File: rtl/layer_stream_unpacker.sv
// Snapshots a layer's flat result bus on layer_done and streams it out element by element
// over valid/ready. Optional UNPACK_RELU_EN applies ReLU on the output mux only.
module layer_stream_unpacker #(
    parameter int N_ELEM = 256,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     layer_done,
    input  logic [DATA_W*N_ELEM-1:0] layer_out_flat,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [IDX_W-1:0]         m_index,
    output logic                     m_last,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     clr_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               overrun_q, overrun_d;
    logic [DATA_W-1:0]  snap_q [N_ELEM];
    logic [DATA_W-1:0]  snap_d [N_ELEM];
    logic               load_s;
    logic               drop_s;
    logic               hs_s;
    logic               at_last_s;
    logic [DATA_W-1:0]  elem_s;
    logic [DATA_W-1:0]  out_s;

`ifdef UNPACK_RELU_EN
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v[DATA_W-1]) begin
            r = '0;
        end else begin
            r = v;
        end
        return r;
    endfunction
`endif

    assign m_valid   = (state_q == ST_STREAM);
    assign busy      = (state_q == ST_STREAM);
    assign at_last_s = (idx_q == LAST_IDX);
    assign hs_s      = m_valid && m_ready;
    assign m_last    = m_valid && at_last_s;
    assign m_index   = idx_q;
    assign overrun   = overrun_q;

    // Stream control: frame acceptance, index advance and dropped-frame detection
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load_s    = 1'b0;
        drop_s    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (layer_done) begin
                    load_s  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (hs_s) begin
                    if (at_last_s) begin
                        idx_d = '0;
                        // A frame arriving on the final handshake chains on with no bubble
                        if (layer_done) begin
                            load_s  = 1'b1;
                            state_d = ST_STREAM;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
                if (layer_done && !(hs_s && at_last_s)) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Snapshot next value: capture the whole bus on an accepted frame, else hold
    always_comb begin
        for (int i = 0; i < N_ELEM; i++) begin
            if (load_s) begin
                snap_d[i] = layer_out_flat[i*DATA_W +: DATA_W];
            end else begin
                snap_d[i] = snap_q[i];
            end
        end
    end

    // Output mux; data is forced to zero whenever nothing is being offered
    always_comb begin
        elem_s = snap_q[idx_q];
`ifdef UNPACK_RELU_EN
        out_s  = relu(elem_s);
`else
        out_s  = elem_s;
`endif
        if (m_valid) begin
            m_data = out_s;
        end else begin
            m_data = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Snapshot storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEM; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ELEM; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

endmodule

// File: tb/tb_layer_stream_unpacker.sv
// Directed bench for layer_stream_unpacker: drains, backpressure, overrun, back-to-back,
// mid-stream reset and activation, with a small table of cycle vectors for stall/overrun corners.
module tb_layer_stream_unpacker;

    localparam int N  = 256;
    localparam int W  = 16;
    localparam int IW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              layer_done;
    logic [W*N-1:0]    layer_out_flat;
    logic              m_valid;
    logic              m_ready;
    logic [W-1:0]      m_data;
    logic [IW-1:0]     m_index;
    logic              m_last;
    logic              busy;
    logic              overrun;
    logic              clr_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic done;
        logic ready;
        logic clr;
        int   pat;
        logic e_valid;
        int   e_idx;
        int   e_dpat;
        logic e_busy;
        logic e_ovr;
    } vec_t;

    vec_t tbl [8];

    layer_stream_unpacker #(.N_ELEM(N), .DATA_W(W), .IDX_W(IW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .layer_done     (layer_done),
        .layer_out_flat (layer_out_flat),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_index        (m_index),
        .m_last         (m_last),
        .busy           (busy),
        .overrun        (overrun),
        .clr_err        (clr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] elem(input int pat, input int i);
        logic [15:0] v;
        case (pat)
            0:       v = 16'(i * 3);
            1:       v = 16'h7FFF;
            2:       v = 16'(65535 - i);
            3:       v = (i == 0) ? 16'hFF00 : ((i == 1) ? 16'h0100 : 16'(i));
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    function automatic logic [15:0] exp_out(input int pat, input int i);
        logic [15:0] v;
        v = elem(pat, i);
`ifdef UNPACK_RELU_EN
        if (v[15]) v = 16'h0000;
`endif
        return v;
    endfunction

    task automatic set_bus(input int pat);
        for (int i = 0; i < N; i++) layer_out_flat[i*W +: W] = elem(pat, i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_elem(input string tag, input int pat, input int i, input logic ovr);
        chk({tag, " valid"},   32'(m_valid), 32'd1);
        chk({tag, " index"},   32'(m_index), 32'(i));
        chk({tag, " data"},    32'(m_data),  32'(exp_out(pat, i)));
        chk({tag, " last"},    32'(m_last),  32'(i == N - 1));
        chk({tag, " busy"},    32'(busy),    32'd1);
        chk({tag, " overrun"}, 32'(overrun), 32'(ovr));
    endtask

    task automatic chk_idle(input string tag, input logic ovr);
        chk({tag, " valid"},   32'(m_valid), 32'd0);
        chk({tag, " data"},    32'(m_data),  32'd0);
        chk({tag, " index"},   32'(m_index), 32'd0);
        chk({tag, " last"},    32'(m_last),  32'd0);
        chk({tag, " busy"},    32'(busy),    32'd0);
        chk({tag, " overrun"}, 32'(overrun), 32'(ovr));
    endtask

    task automatic drain(input string tag, input int pat, input int from, input logic ovr);
        for (int i = from; i < N; i++) begin
            chk_elem(tag, pat, i, ovr);
            step();
        end
    endtask

    task automatic start_frame(input int pat);
        set_bus(pat);
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int stall;
        int cyc;

        //            done  ready clr   pat val   idx dpat busy  ovr
        tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 0, 0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 0, 0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1, 0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 2, 0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1, 1'b1, 2, 0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1, 1'b1, 2, 0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 3, 0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1, 1'b1, 3, 0, 1'b1, 1'b0};

        rst_n = 1'b0;
        layer_done = 1'b0;
        m_ready = 1'b0;
        clr_err = 1'b0;
        set_bus(0);
        #12;
        chk_idle("reset", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic drain
        m_ready = 1'b1;
        set_bus(0);
        layer_done = 1'b1;
        chk("pre-done valid", 32'(m_valid), 32'd0);
        step();
        layer_done = 1'b0;
        drain("basic", 0, 0, 1'b0);
        chk_idle("basic end", 1'b0);

        // Backpressure with a 10-cycle stall at index 7
        start_frame(0);
        e = 0; stall = 0; cyc = 0;
        while (e < N && cyc < 3000) begin
            chk_elem("bp", 0, e, 1'b0);
            if (e == 7 && stall < 10) begin
                m_ready = 1'b0;
                stall++;
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
            step();
            if (m_ready) e++;
            cyc++;
        end
        chk("bp budget", 32'(cyc < 3000), 32'd1);
        m_ready = 1'b1;
        chk_idle("bp end", 1'b0);

        // Table vectors: stall hold, dropped frame, clear vs set priority
        for (int r = 0; r < 8; r++) begin
            layer_done = tbl[r].done;
            m_ready    = tbl[r].ready;
            clr_err    = tbl[r].clr;
            set_bus(tbl[r].pat);
            step();
            chk($sformatf("tbl%0d valid", r),   32'(m_valid), 32'(tbl[r].e_valid));
            chk($sformatf("tbl%0d index", r),   32'(m_index), 32'(tbl[r].e_idx));
            chk($sformatf("tbl%0d data", r),    32'(m_data),  32'(exp_out(tbl[r].e_dpat, tbl[r].e_idx)));
            chk($sformatf("tbl%0d busy", r),    32'(busy),    32'(tbl[r].e_busy));
            chk($sformatf("tbl%0d overrun", r), 32'(overrun), 32'(tbl[r].e_ovr));
        end
        layer_done = 1'b0;
        clr_err    = 1'b0;
        m_ready    = 1'b1;
        drain("tbl tail", 0, 3, 1'b0);
        chk_idle("tbl end", 1'b0);

        // Overrun at index 100, clear+set at 150, plain clear at 160
        start_frame(0);
        for (int i = 0; i < N; i++) begin
            chk_elem("ovr", 0, i, (i > 100) && (i <= 160));
            layer_done = 1'b0;
            clr_err    = 1'b0;
            if (i == 100) begin
                set_bus(1);
                layer_done = 1'b1;
            end
            if (i == 150) begin
                layer_done = 1'b1;
                clr_err    = 1'b1;
            end
            if (i == 160) clr_err = 1'b1;
            step();
        end
        layer_done = 1'b0;
        clr_err    = 1'b0;
        chk_idle("ovr end", 1'b0);

        // Back-to-back: new frame on the final handshake
        start_frame(0);
        for (int i = 0; i < N; i++) begin
            chk_elem("b2b a", 0, i, 1'b0);
            if (i == N - 1) begin
                set_bus(2);
                layer_done = 1'b1;
            end
            step();
            layer_done = 1'b0;
        end
        drain("b2b b", 2, 0, 1'b0);
        chk_idle("b2b end", 1'b0);

        // Reset mid-stream at index 50, with overrun already set
        start_frame(0);
        for (int i = 0; i <= 50; i++) begin
            chk_elem("rst", 0, i, i > 10);
            layer_done = (i == 10);
            if (i < 50) step();
        end
        layer_done = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_idle("rst async", 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_idle("rst release", 1'b0);

        // Restart with the activation bus
        start_frame(3);
`ifdef UNPACK_RELU_EN
        chk("act neg", 32'(m_data), 32'h0000);
`else
        chk("act neg", 32'(m_data), 32'hFF00);
`endif
        chk("act neg index", 32'(m_index), 32'd0);
        step();
        chk("act pos", 32'(m_data), 32'h0100);
        drain("act", 3, 1, 1'b0);
        chk_idle("act end", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
